// File: rtl/led_scan_ctrl_pkg.sv
// Shared types and helpers for the LED scan controller.
// Holds the scan state encoding and the slot-counter width rule.
package led_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    // The slot counter must be able to hold the longer of the two slot lengths.
    function automatic int cnt_width(input int show_cyc, input int blank_cyc);
        int longest;
        longest = (show_cyc > blank_cyc) ? show_cyc : blank_cyc;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/led_scan_ctrl_slot_timer.sv
// Loadable down-counter with a zero flag.
// Shared by the blanking and lit phases of the scan sequence.
module led_scan_ctrl_slot_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // The count parks at zero until the next load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/led_scan_ctrl.sv
// Multiplexes DIGITS hex digits onto one shared 7-segment decoder with
// blanking gaps between digits and frame-synchronous double-buffered updates.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | scan disabled, all outputs low
//   ST_BLANK | gap before a digit slot: no digit driven, decoder disabled
//   ST_SHOW  | digit idx driven, decoder fed active[idx]
module led_scan_ctrl
    import led_scan_ctrl_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int SHOW_CYC  = 4,
    parameter int BLANK_CYC = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                upd_req,
    input  logic [4*DIGITS-1:0] upd_data,
    input  logic [DIGITS-1:0]   blank_mask,
    output logic                upd_busy,
    output logic                upd_ack,
    output logic                dec_en,
    output logic [3:0]          dec_d,
    output logic [DIGITS-1:0]   digit_sel,
    output logic                frame_done
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int CNT_W = cnt_width(SHOW_CYC, BLANK_CYC);

    localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(SHOW_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DIGITS - 1);

    scan_state_t         state;
    scan_state_t         state_nxt;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_nxt;

    logic                tmr_load;
    logic [CNT_W-1:0]    tmr_val;
    logic                cnt_zero;
    logic                frame_end;

    logic [4*DIGITS-1:0] active;
    logic [4*DIGITS-1:0] shadow;
    logic                pending;
    logic                apply;

    logic [DIGITS-1:0]   sel_nxt;
    logic                den_nxt;
    logic [3:0]          dd_nxt;

    led_scan_ctrl_slot_timer #(
        .W (CNT_W)
    ) u_slot_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        frame_end = 1'b0;
        if (!en) begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
            tmr_load  = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_BLANK;
                    idx_nxt   = '0;
                    tmr_load  = 1'b1;
                    tmr_val   = BLANK_LOAD;
                end
                ST_BLANK: begin
                    if (cnt_zero) begin
                        state_nxt = ST_SHOW;
                        tmr_load  = 1'b1;
                        tmr_val   = SHOW_LOAD;
                    end
                end
                ST_SHOW: begin
                    if (cnt_zero) begin
                        state_nxt = ST_BLANK;
                        tmr_load  = 1'b1;
                        tmr_val   = BLANK_LOAD;
                        if (idx == LAST_IDX) begin
                            idx_nxt   = '0;
                            frame_end = 1'b1;
                        end else begin
                            idx_nxt = idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    idx_nxt   = '0;
                    tmr_load  = 1'b1;
                end
            endcase
        end
    end

    // Outputs are registered from the next-state values so they change on
    // the same edge as the state, with no combinational path from inputs.
    always_comb begin
        sel_nxt = '0;
        den_nxt = 1'b0;
        dd_nxt  = dec_d;
        case (state_nxt)
            ST_IDLE: begin
                dd_nxt = 4'h0;
            end
            ST_SHOW: begin
                sel_nxt = {{(DIGITS-1){1'b0}}, 1'b1} << idx_nxt;
                den_nxt = !blank_mask[idx_nxt];
                dd_nxt  = active[int'(idx_nxt)*4 +: 4];
            end
            default: begin
                dd_nxt = dec_d;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit_sel  <= '0;
            dec_en     <= 1'b0;
            dec_d      <= 4'h0;
            frame_done <= 1'b0;
        end else begin
            digit_sel  <= sel_nxt;
            dec_en     <= den_nxt;
            dec_d      <= dd_nxt;
            frame_done <= frame_end;
        end
    end

    // A pending update lands at the frame boundary, or straight away when the
    // scan is not running so an idle display never stalls the host.
    assign apply = pending && (frame_end || (state == ST_IDLE) || !en);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
            upd_ack <= 1'b0;
        end else begin
            upd_ack <= apply;
            if (apply) begin
                active  <= shadow;
                pending <= 1'b0;
            end else if (upd_req && !pending) begin
                shadow  <= upd_data;
                pending <= 1'b1;
            end
        end
    end

    assign upd_busy = pending;

endmodule
